// File: rtl/vencoder_param.sv
// vencoder_param: rate-1/N, constraint-length-K convolutional encoder with
// zero-terminated frames. One data bit is accepted per handshake; its N-bit
// code word is shifted out on a single serial output, c[0] first. After the
// bit flagged in_last, K-1 flush symbols drive the trellis back to state 0.
module vencoder_param #(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = {3'b101, 3'b111}
) (
  input  logic Clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in,
  input  logic in_last,
  output logic in_ready,
  output logic out,
  output logic out_valid,
  output logic out_last,
  output logic busy
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(K);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(K - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [N-1:0]  osr_q, osr_d;
  logic          last_q, last_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          in_ready_q, in_ready_d;

  logic          hs;
  logic          load;
  logic          load_bit;
  logic [K-1:0]  r_full;

  // Code word for input bit b on top of trellis state s; generator j is G[j*K +: K].
  function automatic logic [N-1:0] encode(input logic b, input logic [K-2:0] s);
    logic [K-1:0] r;
    logic [N-1:0] c;
    r = {b, s};
    for (int j = 0; j < N; j++) c[j] = ^(r & G[j*K +: K]);
    return c;
  endfunction

  // Next-state logic: symbol sequencing, tail insertion and output decode.
  always_comb begin
    hs       = in_valid & in_ready_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    sr_d     = sr_q;
    osr_d    = osr_q;
    last_d   = last_q;
    load     = 1'b0;
    load_bit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          load     = 1'b1;
          load_bit = in;
          last_d   = in_last;
          cnt_d    = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
          osr_d = osr_q >> 1;
        end else begin
          cnt_d = '0;
          if (last_q) begin
            // Frame ended: first flush symbol follows with no gap.
            load    = 1'b1;
            tcnt_d  = '0;
            last_d  = 1'b0;
            state_d = S_TAIL;
          end else if (hs) begin
            load     = 1'b1;
            load_bit = in;
            last_d   = in_last;
          end else begin
            osr_d   = osr_q >> 1;
            state_d = S_IDLE;
          end
        end
      end
      S_TAIL: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
          osr_d = osr_q >> 1;
        end else begin
          cnt_d = '0;
          if (tcnt_q != TCNT_LAST) begin
            load   = 1'b1;
            tcnt_d = tcnt_q + 1'b1;
          end else begin
            // sr has shifted in K-1 zeros and is back at state 0.
            osr_d   = osr_q >> 1;
            tcnt_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    r_full = {load_bit, sr_q};
    if (load) begin
      osr_d = encode(load_bit, sr_q);
      sr_d  = r_full[K-1:1];
    end

    // Outputs are decoded from the next state so that every port is a flop.
    out_valid_d = (state_d != S_IDLE);
    out_d       = out_valid_d & osr_d[0];
    out_last_d  = (state_d == S_TAIL) && (tcnt_d == TCNT_LAST) && (cnt_d == CNT_LAST);
    in_ready_d  = (state_d == S_IDLE) ||
                  ((state_d == S_DATA) && (cnt_d == CNT_LAST) && !last_d);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      sr_q        <= '0;
      osr_q       <= '0;
      last_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      sr_q        <= sr_d;
      osr_q       <= osr_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = out_valid_q;

endmodule

// File: tb/tb_vencoder_param.sv
// Bench for vencoder_param: three configurations (K3/N2, K4/N3, K2/N2) share
// clock and reset. A reference encoder pushes expected serial bits into a
// scoreboard at each handshake; a monitor pops and compares on out_valid.
module tb_vencoder_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] in_valid, din, in_last;
  logic [2:0] in_ready, dout, out_valid, out_last, busy;

  vencoder_param #(.K(3), .N(2), .G(6'b101_111)) u_k3 (
    .Clock(clk), .reset(rst_n), .in_valid(in_valid[0]), .in(din[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]), .out(dout[0]), .out_valid(out_valid[0]), .out_last(out_last[0]),
    .busy(busy[0]));

  vencoder_param #(.K(4), .N(3), .G(12'b1101_1011_1111)) u_k4 (
    .Clock(clk), .reset(rst_n), .in_valid(in_valid[1]), .in(din[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]), .out(dout[1]), .out_valid(out_valid[1]), .out_last(out_last[1]),
    .busy(busy[1]));

  vencoder_param #(.K(2), .N(2), .G(4'b01_11)) u_k2 (
    .Clock(clk), .reset(rst_n), .in_valid(in_valid[2]), .in(din[2]), .in_last(in_last[2]),
    .in_ready(in_ready[2]), .out(dout[2]), .out_valid(out_valid[2]), .out_last(out_last[2]),
    .busy(busy[2]));

  localparam int          KA [3] = '{3, 4, 2};
  localparam int          NA [3] = '{2, 3, 2};
  localparam logic [35:0] GA [3] = '{36'h2F, 36'hDBF, 36'h7};

  typedef struct {
    int   inst;
    logic b;
    logic last;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           msr [3];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           nvalid, first_cyc, last_cyc, acc_cyc, prev_cyc;
  logic [255:0] cap;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: one symbol for bit b, expected bits into the scoreboard.
  task automatic push_sym(input int i, input logic b, input logic fin);
    int   r, g;
    logic c;
    r = (int'(b) << (KA[i] - 1)) | msr[i];
    for (int j = 0; j < NA[i]; j++) begin
      g = int'((GA[i] >> (j * KA[i])) & ((36'd1 << KA[i]) - 36'd1));
      c = ^(r & g);
      sbq.push_back('{inst: i, b: c, last: fin && (j == NA[i] - 1)});
    end
    msr[i] = r >> 1;
  endtask

  task automatic model_accept(input int i, input logic b, input logic last);
    push_sym(i, b, 1'b0);
    if (last)
      for (int t = 0; t < KA[i] - 1; t++) push_sym(i, 1'b0, t == KA[i] - 2);
  endtask

  // Present one bit and hold it until the DUT takes it.
  task automatic send(input int i, input logic b, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    in_valid[i] = 1'b1;
    din[i]      = b;
    in_last[i]  = last;
    while (!in_ready[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("hs_wait", int'(t < 200), 1);
    model_accept(i, b, last);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    acc_cyc     = cyc;
  endtask

  // Wait for out_last after the final send; in_ready must stay low meanwhile.
  task automatic wait_last(input int i, input int exp_n);
    int t;
    t = 0;
    while (!out_last[i] && t < 2000) begin
      check("tail_in_ready", int'(in_ready[i]), 0);
      @(negedge clk);
      t++;
    end
    check("last_timeout", int'(t < 2000), 1);
    last_cyc = cyc;
    @(negedge clk);
    check("valid_fall", int'(out_valid[i]), 0);
    check("busy_fall", int'(busy[i]), 0);
    check("ready_rise", int'(in_ready[i]), 1);
    check("frame_bits", nvalid, exp_n);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every valid output bit is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i]) begin
          if (nvalid == 0) first_cyc = cyc;
          nvalid++;
          cap = {cap[254:0], dout[i]};
          check("sb_nonempty", int'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            check("sb_inst", i, mon_e.inst);
            check("out", int'(dout[i]), int'(mon_e.b));
            check("out_last", int'(out_last[i]), int'(mon_e.last));
          end
        end
      end
    end
  end

  logic fr [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    in_valid = '0;
    din      = '0;
    in_last  = '0;
    rst_n    = 1'b0;
    nvalid   = 0;
    cap      = '0;
    msr      = '{0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", int'({dout, out_valid, out_last, busy, in_ready}), 0);
    rst_n = 1'b1;
    #1;
    check("rdy_at_release", int'(in_ready), 0);
    @(negedge clk);
    check("rdy_after_release", int'(in_ready), 7);

    // Back-to-back frame on defaults
    nvalid = 0; cap = '0;
    for (int k = 0; k < 7; k++) begin
      send(0, fr[k], k == 6);
      if (k > 0) check("b2b_hs_period", acc_cyc - prev_cyc, 2);
      prev_cyc = acc_cyc;
    end
    wait_last(0, 18);
    check("frameA_bits", int'(cap[17:0]), int'(18'b00_11_10_00_01_10_01_11_00));
    check("b2b_continuous", last_cyc - first_cyc + 1, 18);

    // Same frame with a 5-cycle source stall after the 3rd bit
    nvalid = 0; cap = '0;
    for (int k = 0; k < 7; k++) begin
      send(0, fr[k], k == 6);
      if (k == 2)
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          if (g >= 2) begin
            check("stall_valid", int'(out_valid[0]), 0);
            check("stall_busy", int'(busy[0]), 0);
          end
        end
    end
    wait_last(0, 18);
    check("stall_bits", int'(cap[17:0]), int'(18'b00_11_10_00_01_10_01_11_00));

    // Reset during the second tail symbol
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("pre_rst_valid", int'(out_valid[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outs", int'({dout[0], out_valid[0], out_last[0], busy[0], in_ready[0]}), 0);
    sbq.delete();
    msr = '{0, 0, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(in_ready[0]), 1);
    check("post_rst_valid", int'(out_valid[0]), 0);
    nvalid = 0; cap = '0;
    send(0, 1'b1, 1'b1);
    wait_last(0, 6);
    check("post_rst_bits", int'(cap[5:0]), int'(6'b11_10_11));

    // K=4, N=3: random 64-bit frame, then a continuation across an idle gap
    nvalid = 0;
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(1, 1'($urandom_range(0, 1)), k == 63);
    end
    wait_last(1, 201);
    nvalid = 0;
    for (int k = 0; k < 5; k++) send(1, 1'($urandom_range(0, 1)), 1'b0);
    repeat (20) @(negedge clk);
    check("cont_idle_busy", int'(busy[1]), 0);
    for (int k = 0; k < 64; k++) send(1, 1'($urandom_range(0, 1)), k == 63);
    wait_last(1, 216);

    // K=2: single tail symbol, two frames
    for (int f = 0; f < 2; f++) begin
      nvalid = 0;
      for (int k = 0; k < 5; k++) send(2, 1'($urandom_range(0, 1)), k == 4);
      wait_last(2, 12);
    end

    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vencoder_param.md
# vencoder_param

Parametrised successor to the fixed rate-1/2, K=3 convolutional encoder. It accepts one data bit per valid/ready handshake and serialises the N-bit code word onto a single output bit, one bit per Clock. Frames are zero-terminated: after the bit flagged `in_last`, the block emits K-1 flush symbols so the matching Viterbi decoder always ends in state 0. It sits between the data source and the serial channel model, feeding the decoder directly.

## Interface
- `K`, default 3: constraint length; legal range 2..9.
- `N`, default 2: code-word bits per input bit (rate 1/N); legal range 2..4.
- `G`, default `{3'b101, 3'b111}`: packed generators, N*K bits; `G[j*K +: K]` is generator j. Bit K-1 taps the current input; bit 0 taps the oldest stored bit.
- `Clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in` and `in_last` are valid.
- `in` input 1: data bit.
- `in_last` input 1: this bit ends the frame; tail follows.
- `in_ready` output 1: block accepts a bit this cycle.
- `out` output 1: serial code bit.
- `out_valid` output 1: `out` carries a code bit.
- `out_last` output 1: final bit of the frame's last tail symbol.
- `busy` output 1: state is not IDLE.

## Operation
- State register `sr[K-2:0]`; `sr[K-2]` is the newest bit. On each accepted or tail bit b:
  - form `r = {b, sr}` (K bits);
  - compute `c[j] = ^(r & G[j*K +: K])` for j = 0..N-1;
  - update `sr <= {b, sr[K-2:1]}`.
- Code word `c` loads into an N-bit output shift register. Bits go out in the order `c[0]` first, `c[N-1]` last.
- Symbol counter `cnt` is $clog2(N) bits wide. It counts 0..N-1 within a symbol and wraps to 0.
- Tail counter `tcnt` is $clog2(K) bits wide. It counts K-1 flush symbols.
- FSM states and transitions:
  - IDLE: `in_ready=1`. On a handshake, load the code word and go to DATA with `cnt=0`.
  - DATA: emit one bit per cycle. At `cnt==N-1`:
    - if the current symbol was `in_last`, load tail symbol 0 and go to TAIL;
    - else if a handshake occurs, load the next word and stay in DATA;
    - else go to IDLE.
  - TAIL: emit bits of flush symbols (input 0). At `cnt==N-1`:
    - if more tail symbols remain, load the next;
    - else go to IDLE. `sr` is now all zero.
- `in_ready` = (IDLE) or (DATA and `cnt==N-1` and current symbol not `in_last`). It is always 0 in TAIL.
- `in_last` is sampled only on a handshake. The flag is stored with the symbol.
- `out_last` = 1 only in TAIL, on the last tail symbol, at `cnt==N-1`.
- When the source stalls, `sr` is retained across IDLE. A new frame without a preceding `in_last` continues the trellis from the retained state.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - `out=0`, `out_valid=0`, `out_last=0`, `busy=0`, `in_ready=0` while reset is low;
  - `sr=0`, `cnt=0`, `tcnt=0`, state IDLE.
  - `in_ready` rises the first cycle after release.
- Latency: for a bit accepted at rising edge t, `c[0]` appears on `out` with `out_valid=1` in cycle t+1. `c[N-1]` appears in cycle t+N.
- Throughput: with `in_valid` held high, one bit is accepted every N cycles and `out_valid` stays high with no gap.
- Frame of L bits: exactly (L+K-1)*N valid output bits, then `out_valid` falls the cycle after `out_last`.
- Reset mid-frame aborts immediately. No partial symbol or tail is emitted after release.
- All outputs are registered. No combinational path from `in` to `out`.

## Test plan
- Defaults (K=3, N=2, G=111/101). Feed frame 0,1,0,1,1,1,0 with `in_last` on the final 0 → serial out = 00 11 10 00 01 10 01 11 00 (18 bits). `out_last` is on bit 18; `sr=00` afterwards.
- Back-to-back: `in_valid` held high on the same frame → a handshake every 2 cycles, `out_valid` continuous for 18 cycles, and `in_ready=0` for all 4 tail cycles.
- Stall: drop `in_valid` for 5 cycles after the 3rd bit → `out_valid` low for the gap, `busy=0`, and the remaining bits are identical to the unstalled stream.
- Reset asserted during the 2nd tail symbol → all outputs 0 asynchronously. After release: `in_ready=1`, `out_valid=0`, and a new single-bit frame "1"+last yields 11 10 11.
- K=4, N=3, G={1101,1011,1111}, random 64-bit frames → bit-exact match against the reference model, 3*(64+3)=201 output bits per frame.
- K=2 boundary: single tail symbol, and `tcnt` wrap at the smallest width → `out_last` on bit (L+1)*N.
